// File: rtl/io_port_bank.sv
// io_port_bank: CPU I/O port pair.
// Input side: a circular FIFO filled by an external producer and drained by the CPU.
// Output side: a one-word output register with a valid/ack handshake to an external consumer.
// Errors are sticky and are cleared by a synchronous clear.

module io_port_bank #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    clr,
    // External producer
    input  logic [WIDTH-1:0]        inport_data_in,
    input  logic                    inport_strobe,
    output logic                    inport_full,
    // CPU read side
    input  logic                    InPortout,
    output logic [WIDTH-1:0]        bus_data,
    output logic                    in_empty,
    output logic [$clog2(DEPTH):0]  in_count,
    // CPU write side
    input  logic                    OutPort_enable,
    input  logic [WIDTH-1:0]        bus_contents,
    // External consumer
    output logic [WIDTH-1:0]        outport_data_out,
    output logic                    outport_valid,
    input  logic                    outport_ack,
    // Status
    output logic [2:0]              err_flags,
    input  logic                    err_clear
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } out_state_e;

    // Input FIFO state
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;

    // Output side state
    out_state_e       out_state_q;
    logic [WIDTH-1:0] out_data_q;

    logic [2:0]       err_q;

    // Per-edge events
    logic fifo_full;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic in_overflow;
    logic in_underflow;
    logic out_overrun;

    // Decode push/pop and error events from current occupancy and requests
    always_comb begin
        fifo_full    = (count_q == FullCount);
        fifo_empty   = (count_q == '0);
        do_pop       = InPortout & ~fifo_empty;
        // A same-edge pop frees a slot, so a full FIFO can still accept the push.
        do_push      = inport_strobe & (~fifo_full | do_pop);
        in_overflow  = inport_strobe & fifo_full & ~do_pop;
        // Push into empty with same-edge read is still an underflow; no bypass.
        in_underflow = InPortout & fifo_empty;
        out_overrun  = (out_state_q == StPending) & OutPort_enable & ~outport_ack;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // FIFO storage; contents are don't-care after reset since empty gates the read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= inport_data_in;
        end
    end

    // Output handshake FSM with its data register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_state_q <= StIdle;
            out_data_q  <= '0;
        end else begin
            case (out_state_q)
                StIdle: begin
                    if (OutPort_enable) begin
                        out_data_q  <= bus_contents;
                        out_state_q <= StPending;
                    end
                end
                StPending: begin
                    // A new write always wins; ack only retires the word when no write arrives.
                    if (OutPort_enable) begin
                        out_data_q <= bus_contents;
                    end else if (outport_ack) begin
                        out_state_q <= StIdle;
                    end
                end
                default: begin
                    out_state_q <= StIdle;
                end
            endcase
        end
    end

    // Sticky error flags; a new error on the clearing edge survives the clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_q <= '0;
        end else if (err_clear) begin
            err_q <= {out_overrun, in_underflow, in_overflow};
        end else begin
            err_q <= err_q | {out_overrun, in_underflow, in_overflow};
        end
    end

    // Output drive
    always_comb begin
        bus_data         = do_pop ? mem[rd_ptr_q] : '0;
        inport_full      = fifo_full;
        in_empty         = fifo_empty;
        in_count         = count_q;
        outport_data_out = out_data_q;
        outport_valid    = (out_state_q == StPending);
        err_flags        = err_q;
    end

endmodule
